level_tick_gen: RTL and testbench

Parametrised successor to the 4-level clock-select mux in the Genius game datapath. It derives one-cycle game-speed ticks from the system clock at a rate chosen by the difficulty level, with no separately divided clocks. A level change takes effect only at a tick boundary, so the game sequencer never sees a runt or stretched period. It feeds the sequence-playback and timeout logic in place of the selected CLKHZ signal.

---
 rtl/genius_pkg.sv | 35 +++
 rtl/level_tick_gen_if.sv | 22 ++
 rtl/tick_prescaler.sv | 29 ++
 rtl/level_tick_gen.sv | 78 +++++++
 tb/tb_level_tick_gen.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/genius_pkg.sv
// Shared constants and helpers for the Genius game-speed tick logic.
// Holds the default 50 MHz divisor table and the level/divisor lookup functions.
package genius_pkg;

  localparam int DEFAULT_NUM_LEVELS = 4;
  localparam int DEFAULT_CNT_W      = 26;

  // Level 0 sits in the LSBs: 1 Hz, 2 Hz, 4 Hz, 8 Hz at 50 MHz.
  localparam logic [DEFAULT_NUM_LEVELS*DEFAULT_CNT_W-1:0] DEFAULT_DIV_TABLE =
    {26'd6_250_000, 26'd12_500_000, 26'd25_000_000, 26'd50_000_000};

  // Tables are zero-extended to this width so one lookup function serves every build.
  localparam int TBL_MAX_W = 1024;

  function automatic int lvl_w_of(input int num_levels);
    return (num_levels <= 2) ? 1 : $clog2(num_levels);
  endfunction

  function automatic int unsigned clamp_lvl(input int unsigned lvl,
                                            input int unsigned num_levels);
    return (lvl >= num_levels) ? (num_levels - 1) : lvl;
  endfunction

  function automatic logic [31:0] div_of(input logic [TBL_MAX_W-1:0] tbl,
                                         input int unsigned          lvl,
                                         input int unsigned          num_levels,
                                         input int unsigned          cnt_w);
    int unsigned            l;
    logic [TBL_MAX_W-1:0]   sh;
    l  = clamp_lvl(lvl, num_levels);
    sh = tbl >> (l * cnt_w);
    return sh[31:0] & ((32'h1 << cnt_w) - 32'h1);
  endfunction

endpackage

// File: rtl/level_tick_gen_if.sv
// Control/status bundle between the game sequencer and the tick generator.
// level/enable/restart are sampled every rising edge; tick is a one-cycle pulse.
interface level_tick_gen_if #(
  parameter int LVL_W = 2
);
  logic             enable;
  logic             restart;
  logic [LVL_W-1:0] level;
  logic             tick;
  logic [LVL_W-1:0] active_level;
  logic             level_pending;

  modport master (
    output enable, restart, level,
    input  tick, active_level, level_pending
  );

  modport slave (
    input  enable, restart, level,
    output tick, active_level, level_pending
  );
endinterface

// File: rtl/tick_prescaler.sv
// Loadable down-counter; load has priority over the decrement.
// zero flags the terminal count so the owner can decide when to reload.
module tick_prescaler #(
  parameter int               CNT_W   = 26,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/level_tick_gen.sv
// Game-speed tick generator: one-cycle ticks every DIV_TABLE[active_level] enabled clocks.
// Level changes while counting are deferred to the reload so no period is ever cut short.
module level_tick_gen
  import genius_pkg::*;
#(
  parameter int                              NUM_LEVELS = DEFAULT_NUM_LEVELS,
  parameter int                              LVL_W      = lvl_w_of(NUM_LEVELS),
  parameter int                              CNT_W      = DEFAULT_CNT_W,
  parameter logic [NUM_LEVELS*CNT_W-1:0]     DIV_TABLE  = DEFAULT_DIV_TABLE
) (
  input  logic               clock,
  input  logic               reset_n,
  level_tick_gen_if.slave    bus
);

  localparam logic [TBL_MAX_W-1:0] TBL_EXT = TBL_MAX_W'(DIV_TABLE);
  localparam logic [CNT_W-1:0]     RST_CNT =
    CNT_W'(div_of(TBL_EXT, 0, NUM_LEVELS, CNT_W) - 32'd1);

  logic [LVL_W-1:0] lvl_c;
  logic [LVL_W-1:0] active_q;
  logic             tick_q;
  logic [31:0]      div_req;
  logic [CNT_W-1:0] reload_val;
  logic             lvl_diff;
  logic             zero;
  logic             load;
  logic             en;

  assign lvl_c      = LVL_W'(clamp_lvl(32'(bus.level), NUM_LEVELS));
  assign div_req    = div_of(TBL_EXT, 32'(lvl_c), NUM_LEVELS, CNT_W);
  assign reload_val = CNT_W'(div_req - 32'd1);
  assign lvl_diff   = (lvl_c != active_q);

  // restart beats everything; while disabled only a real level change reloads.
  always_comb begin
    load = 1'b0;
    en   = 1'b0;
    if (bus.restart) begin
      load = 1'b1;
    end else if (!bus.enable) begin
      load = lvl_diff;
    end else if (zero) begin
      load = 1'b1;
    end else begin
      en = 1'b1;
    end
  end

  tick_prescaler #(
    .CNT_W   (CNT_W),
    .RST_VAL (RST_CNT)
  ) u_prescaler (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (reload_val),
    .en       (en),
    .zero     (zero)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_q   <= 1'b0;
      active_q <= '0;
    end else begin
      tick_q <= !bus.restart && bus.enable && zero;
      if (load) begin
        active_q <= lvl_c;
      end
    end
  end

  assign bus.tick          = tick_q;
  assign bus.active_level  = active_q;
  assign bus.level_pending = lvl_diff;

endmodule

// File: tb/tb_level_tick_gen.sv
// Directed bench for level_tick_gen: a 4-level build (8/6/4/2) and a 3-level build (8/1/4).
// Tick times are recorded as negedge offsets from the negedge where enable was raised.
module tb_level_tick_gen;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  level_tick_gen_if #(.LVL_W(2)) bus_a ();
  level_tick_gen_if #(.LVL_W(2)) bus_b ();

  level_tick_gen #(
    .NUM_LEVELS (4),
    .LVL_W      (2),
    .CNT_W      (4),
    .DIV_TABLE  ({4'd2, 4'd4, 4'd6, 4'd8})
  ) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  level_tick_gen #(
    .NUM_LEVELS (3),
    .LVL_W      (2),
    .CNT_W      (4),
    .DIV_TABLE  ({4'd4, 4'd1, 4'd8})
  ) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // Reset both DUTs, let one disabled edge adopt the requested levels, then enable.
  task automatic start(input logic [1:0] la, input logic [1:0] lb);
    @(negedge clock);
    reset_n       = 1'b0;
    bus_a.enable  = 1'b0;
    bus_a.restart = 1'b0;
    bus_a.level   = la;
    bus_b.enable  = 1'b0;
    bus_b.restart = 1'b0;
    bus_b.level   = lb;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    bus_a.enable = 1'b1;
    bus_b.enable = 1'b1;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset;
    bus_a.enable = 1'b0; bus_a.restart = 1'b0; bus_a.level = 2'd2;
    bus_b.enable = 1'b0; bus_b.restart = 1'b0; bus_b.level = 2'd3;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus_a.tick !== 1'b0) begin
      n_fail++; $display("FAIL reset_tick: got %0b expected 0", bus_a.tick);
    end
    n_cmp++;
    if (bus_a.active_level !== 2'd0) begin
      n_fail++; $display("FAIL reset_active: got %0d expected 0", bus_a.active_level);
    end
    n_cmp++;
    if (bus_a.level_pending !== 1'b1) begin
      n_fail++; $display("FAIL reset_pending_lvl2: got %0b expected 1", bus_a.level_pending);
    end
    n_cmp++;
    if (bus_b.level_pending !== 1'b1) begin
      n_fail++; $display("FAIL reset_pending_clamped: got %0b expected 1", bus_b.level_pending);
    end
    bus_a.level = 2'd0;
    #1;
    n_cmp++;
    if (bus_a.level_pending !== 1'b0) begin
      n_fail++; $display("FAIL reset_pending_lvl0: got %0b expected 0", bus_a.level_pending);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_cmp++;
      if (bus_a.tick !== 1'b0) begin
        n_fail++; $display("FAIL disabled_no_tick: got %0b expected 0 at k=%0d", bus_a.tick, k);
      end
    end
  endtask

  task automatic test_basic;
    start(2'd0, 2'd0);
    exp_q = '{8'd8, 8'd16, 8'd24};
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock);
      if (bus_a.tick) got_q.push_back(8'(k));
    end
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL basic_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL basic_tick[%0d]: got %0d expected %0d", i,
                           (i < got_q.size()) ? got_q[i] : 8'hff, exp_q[i]);
      end
    end
    n_cmp++;
    if (bus_a.active_level !== 2'd0 || bus_a.level_pending !== 1'b0) begin
      n_fail++; $display("FAIL basic_status: got lvl=%0d pend=%0b expected lvl=0 pend=0",
                         bus_a.active_level, bus_a.level_pending);
    end
  endtask

  task automatic test_level_change;
    start(2'd0, 2'd0);
    exp_q = '{8'd8, 8'd16, 8'd20, 8'd24};
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock);
      if (bus_a.tick) got_q.push_back(8'(k));
      if (k == 15) begin
        n_cmp++;
        if (bus_a.level_pending !== 1'b1 || bus_a.active_level !== 2'd0) begin
          n_fail++; $display("FAIL chg_before_reload: got pend=%0b lvl=%0d expected pend=1 lvl=0",
                             bus_a.level_pending, bus_a.active_level);
        end
      end
      if (k == 16) begin
        n_cmp++;
        if (bus_a.level_pending !== 1'b0 || bus_a.active_level !== 2'd2) begin
          n_fail++; $display("FAIL chg_adopted: got pend=%0b lvl=%0d expected pend=0 lvl=2",
                             bus_a.level_pending, bus_a.active_level);
        end
      end
      if (k == 10) begin
        bus_a.level = 2'd2;
        #1;
        n_cmp++;
        if (bus_a.level_pending !== 1'b1) begin
          n_fail++; $display("FAIL chg_pending_rise: got %0b expected 1", bus_a.level_pending);
        end
      end
    end
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL chg_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL chg_tick[%0d]: got %0d expected %0d", i,
                           (i < got_q.size()) ? got_q[i] : 8'hff, exp_q[i]);
      end
    end
  endtask

  task automatic test_level_pulse;
    start(2'd0, 2'd0);
    exp_q = '{8'd8, 8'd16, 8'd24};
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock);
      if (bus_a.tick) got_q.push_back(8'(k));
      if (k == 10) begin
        bus_a.level = 2'd3;
        #1;
        n_cmp++;
        if (bus_a.level_pending !== 1'b1) begin
          n_fail++; $display("FAIL pulse_pending_high: got %0b expected 1", bus_a.level_pending);
        end
      end
      if (k == 12) begin
        bus_a.level = 2'd0;
        #1;
        n_cmp++;
        if (bus_a.level_pending !== 1'b0) begin
          n_fail++; $display("FAIL pulse_pending_low: got %0b expected 0", bus_a.level_pending);
        end
      end
    end
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL pulse_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL pulse_tick[%0d]: got %0d expected %0d", i,
                           (i < got_q.size()) ? got_q[i] : 8'hff, exp_q[i]);
      end
    end
    n_cmp++;
    if (bus_a.active_level !== 2'd0) begin
      n_fail++; $display("FAIL pulse_active: got %0d expected 0", bus_a.active_level);
    end
  endtask

  task automatic test_enable_gap;
    start(2'd1, 2'd0);
    exp_q = '{8'd6, 8'd15, 8'd21};
    n_cmp++;
    if (bus_a.active_level !== 2'd1) begin
      n_fail++; $display("FAIL gap_disabled_adopt: got %0d expected 1", bus_a.active_level);
    end
    for (int k = 1; k <= 22; k++) begin
      @(negedge clock);
      if (bus_a.tick) got_q.push_back(8'(k));
      if (k == 8)  bus_a.enable = 1'b0;
      if (k == 11) bus_a.enable = 1'b1;
    end
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL gap_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL gap_tick[%0d]: got %0d expected %0d", i,
                           (i < got_q.size()) ? got_q[i] : 8'hff, exp_q[i]);
      end
    end
  endtask

  task automatic test_restart;
    start(2'd0, 2'd0);
    exp_q = '{8'd8, 8'd18, 8'd20, 8'd22};
    for (int k = 1; k <= 23; k++) begin
      @(negedge clock);
      if (bus_a.tick) got_q.push_back(8'(k));
      if (k == 15) begin
        bus_a.restart = 1'b1;
        bus_a.level   = 2'd3;
      end
      if (k == 16) begin
        bus_a.restart = 1'b0;
        n_cmp++;
        if (bus_a.tick !== 1'b0 || bus_a.active_level !== 2'd3) begin
          n_fail++; $display("FAIL restart_apply: got tick=%0b lvl=%0d expected tick=0 lvl=3",
                             bus_a.tick, bus_a.active_level);
        end
      end
    end
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL restart_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL restart_tick[%0d]: got %0d expected %0d", i,
                           (i < got_q.size()) ? got_q[i] : 8'hff, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    start(2'd2, 2'd0);
    exp_q = '{8'd4, 8'd8, 8'd17, 8'd21};
    for (int k = 1; k <= 22; k++) begin
      @(negedge clock);
      if (bus_a.tick) got_q.push_back(8'(k));
      if (k == 8) begin
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus_a.tick !== 1'b0 || bus_a.active_level !== 2'd0) begin
          n_fail++; $display("FAIL rstmid_async: got tick=%0b lvl=%0d expected tick=0 lvl=0",
                             bus_a.tick, bus_a.active_level);
        end
      end
      if (k == 9) reset_n = 1'b1;
      if (k == 17) begin
        n_cmp++;
        if (bus_a.active_level !== 2'd2) begin
          n_fail++; $display("FAIL rstmid_readopt: got %0d expected 2", bus_a.active_level);
        end
      end
    end
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL rstmid_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rstmid_tick[%0d]: got %0d expected %0d", i,
                           (i < got_q.size()) ? got_q[i] : 8'hff, exp_q[i]);
      end
    end
  endtask

  task automatic test_clamp_div1;
    start(2'd0, 2'd3);
    exp_q = '{8'd4, 8'd8, 8'd12, 8'd13, 8'd14, 8'd15};
    n_cmp++;
    if (bus_b.active_level !== 2'd2 || bus_b.level_pending !== 1'b0) begin
      n_fail++; $display("FAIL clamp_status: got lvl=%0d pend=%0b expected lvl=2 pend=0",
                         bus_b.active_level, bus_b.level_pending);
    end
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      if (bus_b.tick) got_q.push_back(8'(k));
      if (k == 9) bus_b.level = 2'd1;
      if (k == 12) begin
        n_cmp++;
        if (bus_b.active_level !== 2'd1) begin
          n_fail++; $display("FAIL div1_adopt: got %0d expected 1", bus_b.active_level);
        end
      end
    end
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL clamp_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL clamp_tick[%0d]: got %0d expected %0d", i,
                           (i < got_q.size()) ? got_q[i] : 8'hff, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_level_change();
    test_level_pulse();
    test_enable_gap();
    test_restart();
    test_reset_mid();
    test_clamp_div1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
